// File: rtl/monitor_break_unit.sv
// Breakpoint/trigger unit on the monitor control-register bus: NUM_CH comparator
// channels with ignore mask, pass count, chain-to-previous and auto-rearm.
// Ports: register bus (addr/data_in/read_en/write_en -> write_done/data_out),
//        compare input (cmp_val/cmp_strobe), sticky hit flags and stop_req pulse.
// Latency: reads, write_done, hit and stop_req all appear one cycle after the request/strobe.
module monitor_break_unit #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CMP_W  = 16,
  parameter int unsigned CNT_W  = 12,
  parameter logic [15:0] BASE   = 16'h0040
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       addr,
  input  logic [15:0]       data_in,
  input  logic              read_en,
  input  logic              write_en,
  output logic              write_done,
  output logic [15:0]       data_out,
  input  logic [CMP_W-1:0]  cmp_val,
  input  logic              cmp_strobe,
  output logic [NUM_CH-1:0] hit,
  output logic              stop_req
);

  // Window covers the channel registers plus a 4-word global group
  // (STATUS, CLEAR and two reserved words that read 0 but are acknowledged).
  localparam int unsigned WIN = 4 * NUM_CH + 4;

  logic [CMP_W-1:0] value_q [NUM_CH];
  logic [CMP_W-1:0] ign_q   [NUM_CH];
  logic [CNT_W-1:0] pass_q  [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [NUM_CH-1:0] en_q, chain_q, auto_q, hit_q;

  logic [16:0] diff;
  logic [15:0] off;
  logic        in_win, wr_acc, rd_acc, clear_wr;

  // A 17-bit difference makes addresses below BASE wrap to large values,
  // so one unsigned compare handles both ends of the window.
  assign diff     = {1'b0, addr} - {1'b0, BASE};
  assign off      = diff[15:0];
  assign in_win   = diff < 17'(WIN);
  assign wr_acc   = write_en && in_win;
  assign rd_acc   = read_en && in_win;
  assign clear_wr = wr_acc && (off == 16'(4 * NUM_CH + 1));

  logic [NUM_CH:0]   prev_hit;
  logic [NUM_CH-1:0] match, wr_clr, elig, fire;
  logic [15:0]       rd_data;

  always_comb begin
    // Bit 0 is tied high so channel 0 never waits on a predecessor.
    prev_hit = {hit_q, 1'b1};
    match    = '0;
    wr_clr   = '0;
    elig     = '0;
    fire     = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      match[c]  = ((cmp_val ^ value_q[c]) & ~ign_q[c]) == '0;
      wr_clr[c] = wr_acc && ((off == 16'(4 * c + 2)) || (off == 16'(4 * c + 3)));
      // Registered predecessor hit only: no same-cycle cascade down the chain.
      // A non-auto channel that has hit stays disarmed until cleared.
      elig[c]   = cmp_strobe && en_q[c] && match[c]
                  && (!chain_q[c] || prev_hit[c])
                  && (!hit_q[c] || auto_q[c])
                  && !wr_clr[c] && !clear_wr;
      fire[c]   = elig[c] && (cnt_q[c] == pass_q[c]);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (off == 16'(4 * c))     rd_data = 16'(value_q[c]);
      if (off == 16'(4 * c + 1)) rd_data = 16'(ign_q[c]);
      if (off == 16'(4 * c + 2)) rd_data = 16'(pass_q[c]);
      if (off == 16'(4 * c + 3)) rd_data = {12'(cnt_q[c]), 1'b0, auto_q[c], chain_q[c], en_q[c]};
    end
    if (off == 16'(4 * NUM_CH)) rd_data = 16'(hit_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_done <= 1'b0;
      data_out   <= '0;
      stop_req   <= 1'b0;
      en_q       <= '0;
      chain_q    <= '0;
      auto_q     <= '0;
      hit_q      <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        value_q[c] <= '0;
        ign_q[c]   <= '0;
        pass_q[c]  <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      write_done <= wr_acc;
      data_out   <= rd_acc ? rd_data : 16'h0000;
      stop_req   <= |fire;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (wr_acc && off == 16'(4 * c))     value_q[c] <= data_in[CMP_W-1:0];
        if (wr_acc && off == 16'(4 * c + 1)) ign_q[c]   <= data_in[CMP_W-1:0];
        if (wr_acc && off == 16'(4 * c + 2)) pass_q[c]  <= data_in[CNT_W-1:0];
        if (wr_acc && off == 16'(4 * c + 3)) begin
          en_q[c]    <= data_in[0];
          chain_q[c] <= data_in[1];
          auto_q[c]  <= data_in[2];
        end
        // Reconfiguration or CLEAR takes priority over a coincident strobe.
        if (wr_clr[c] || clear_wr) begin
          cnt_q[c] <= '0;
          hit_q[c] <= 1'b0;
        end else if (fire[c]) begin
          hit_q[c] <= 1'b1;
          if (auto_q[c]) cnt_q[c] <= '0;
        end else if (elig[c]) begin
          cnt_q[c] <= cnt_q[c] + 1'b1;
        end
      end
    end
  end

  assign hit = hit_q;

endmodule

// File: tb/tb_monitor_break_unit.sv
module tb_monitor_break_unit;

  localparam int NCH = 4;
  localparam logic [15:0] BASE = 16'h0040;
  localparam logic [15:0] A_STATUS = BASE + 16'(4 * NCH);
  localparam logic [15:0] A_CLEAR  = BASE + 16'(4 * NCH + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0, data_in = '0, data_out;
  logic        read_en = 1'b0, write_en = 1'b0, write_done;
  logic [15:0] cmp_val = '0;
  logic        cmp_strobe = 1'b0;
  logic [NCH-1:0] hit;
  logic        stop_req;

  int tests = 0;
  int fails = 0;

  monitor_break_unit #(.NUM_CH(NCH), .CMP_W(16), .CNT_W(12), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
    .read_en(read_en), .write_en(write_en), .write_done(write_done),
    .data_out(data_out), .cmp_val(cmp_val), .cmp_strobe(cmp_strobe),
    .hit(hit), .stop_req(stop_req)
  );

  always #5 clk = ~clk;

  // Reference model: register file as arrays, channels evaluated by the rules.
  logic [15:0] m_val [NCH];
  logic [15:0] m_ign [NCH];
  logic [11:0] m_pass [NCH];
  logic [11:0] m_cnt [NCH];
  logic [2:0]  m_ctrl [NCH];   // {auto, chain, en}
  logic [NCH-1:0] m_hit;
  logic        e_wd, e_stop;
  logic [15:0] e_do;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_val[c] = 0; m_ign[c] = 0; m_pass[c] = 0; m_cnt[c] = 0; m_ctrl[c] = 0;
    end
    m_hit = 0; e_wd = 0; e_stop = 0; e_do = 0;
  endtask

  function automatic logic [15:0] model_read(input int off);
    if (off < 4 * NCH) begin
      case (off % 4)
        0: return m_val[off / 4];
        1: return m_ign[off / 4];
        2: return {4'h0, m_pass[off / 4]};
        default: return {m_cnt[off / 4], 1'b0, m_ctrl[off / 4]};
      endcase
    end
    if (off == 4 * NCH) return {12'h000, m_hit};
    return 16'h0000;
  endfunction

  task automatic model_cycle(input logic we, input logic re, input logic [15:0] a,
                             input logic [15:0] d, input logic stb, input logic [15:0] v);
    int off;
    logic inwin, clr_all, touched, fired, pred_ok, armed, matched;
    logic [NCH-1:0] old_hit;
    off     = int'(a) - int'(BASE);
    inwin   = (off >= 0) && (off < 4 * NCH + 4);
    e_do    = (re && inwin) ? model_read(off) : 16'h0000;
    e_wd    = we && inwin;
    old_hit = m_hit;
    fired   = 1'b0;
    clr_all = e_wd && (off == 4 * NCH + 1);
    for (int c = 0; c < NCH; c++) begin
      touched = e_wd && (off < 4 * NCH) && (off / 4 == c) && (off % 4 >= 2);
      matched = ((v ^ m_val[c]) & ~m_ign[c]) == 16'h0000;
      pred_ok = (c == 0) || !m_ctrl[c][1] || old_hit[(c == 0) ? 0 : c - 1];
      armed   = !old_hit[c] || m_ctrl[c][2];
      if (clr_all || touched) begin
        m_cnt[c] = 0;
        m_hit[c] = 1'b0;
      end else if (stb && m_ctrl[c][0] && matched && pred_ok && armed) begin
        if (m_cnt[c] == m_pass[c]) begin
          m_hit[c] = 1'b1;
          fired = 1'b1;
          if (m_ctrl[c][2]) m_cnt[c] = 0;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
    end
    if (e_wd && off < 4 * NCH) begin
      case (off % 4)
        0: m_val[off / 4]  = d;
        1: m_ign[off / 4]  = d;
        2: m_pass[off / 4] = d[11:0];
        default: m_ctrl[off / 4] = d[2:0];
      endcase
    end
    e_stop = fired;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus/strobe cycle, driven after a falling edge and checked at the next one.
  task automatic step(input logic we, input logic re, input logic [15:0] a,
                      input logic [15:0] d, input logic stb, input logic [15:0] v);
    write_en = we; read_en = re; addr = a; data_in = d; cmp_strobe = stb; cmp_val = v;
    model_cycle(we, re, a, d, stb, v);
    @(posedge clk);
    @(negedge clk);
    write_en = 0; read_en = 0; cmp_strobe = 0;
    check("hit", {12'h000, hit}, {12'h000, m_hit});
    check("stop_req", {15'h0, stop_req}, {15'h0, e_stop});
    check("write_done", {15'h0, write_done}, {15'h0, e_wd});
    check("data_out", data_out, e_do);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(1'b1, 1'b0, a, d, 1'b0, 16'h0);
  endtask
  task automatic rd(input logic [15:0] a);
    step(1'b0, 1'b1, a, 16'h0, 1'b0, 16'h0);
  endtask
  task automatic stb(input logic [15:0] v);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, v);
  endtask

  logic [15:0] pool [4] = '{16'hA5A5, 16'h5A5A, 16'h0F0F, 16'h1234};
  logic [15:0] igns [4] = '{16'h0000, 16'h000F, 16'hFF00, 16'h0000};

  initial begin
    int off;
    logic [15:0] a, d, v;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_hit", {12'h000, hit}, 16'h0000);
    check("rst_stop", {15'h0, stop_req}, 16'h0000);
    check("rst_data_out", data_out, 16'h0000);
    check("rst_write_done", {15'h0, write_done}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic match on channel 0.
    wr(BASE + 0, 16'h0C23); wr(BASE + 1, 16'h0000); wr(BASE + 2, 16'h0000); wr(BASE + 3, 16'h0001);
    stb(16'h0C23);
    check("basic_hit", {12'h000, hit}, 16'h0001);
    check("basic_stop", {15'h0, stop_req}, 16'h0001);
    stb(16'h0C24);
    check("nomatch_stop", {15'h0, stop_req}, 16'h0000);
    check("nomatch_hit", {12'h000, hit}, 16'h0001);

    // Masking.
    wr(BASE + 0, 16'h1230); wr(BASE + 1, 16'h000F); wr(BASE + 3, 16'h0001);
    check("ctrl_write_clears_hit", {12'h000, hit}, 16'h0000);
    stb(16'h123A);
    check("mask_hit", {12'h000, hit}, 16'h0001);
    wr(BASE + 3, 16'h0001);
    stb(16'h1330);
    check("mask_miss", {12'h000, hit}, 16'h0000);

    // Pass count: hit on 4th strobe.
    wr(BASE + 0, 16'h5555); wr(BASE + 1, 16'h0000); wr(BASE + 2, 16'h0003); wr(BASE + 3, 16'h0001);
    stb(16'h5555); stb(16'h5555);
    rd(BASE + 3);
    check("ctrl_read_cnt2", data_out, 16'h0021);
    stb(16'h5555);
    check("pass_3rd_no_hit", {12'h000, hit}, 16'h0000);
    stb(16'h5555);
    check("pass_4th_hit", {12'h000, hit}, 16'h0001);

    // Auto-rearm: stop on every second strobe.
    wr(BASE + 2, 16'h0001); wr(BASE + 3, 16'h0005);
    for (int i = 1; i <= 6; i++) begin
      stb(16'h5555);
      check($sformatf("auto_stop_%0d", i), {15'h0, stop_req}, (i % 2 == 0) ? 16'h0001 : 16'h0000);
    end

    // Chain: channel 1 waits for channel 0.
    wr(A_CLEAR, 16'h0000);
    wr(BASE + 0, 16'h1111); wr(BASE + 2, 16'h0000); wr(BASE + 3, 16'h0001);
    wr(BASE + 4, 16'h2222); wr(BASE + 7, 16'h0003);
    stb(16'h2222);
    check("chain_ignored", {12'h000, hit}, 16'h0000);
    stb(16'h1111);
    check("chain_ch0", {12'h000, hit}, 16'h0001);
    stb(16'h2222);
    check("chain_both", {12'h000, hit}, 16'h0003);
    wr(BASE + 4, 16'h1111); wr(A_CLEAR, 16'h0000);
    stb(16'h1111);
    check("chain_no_cascade", {12'h000, hit}, 16'h0001);
    stb(16'h1111);
    check("chain_next", {12'h000, hit}, 16'h0003);
    rd(A_STATUS);
    check("status_read", data_out, 16'h0003);

    // CLEAR collides with a matching strobe.
    wr(BASE + 3, 16'h0001);
    step(1'b1, 1'b0, A_CLEAR, 16'h0000, 1'b1, 16'h1111);
    check("clear_wins_hit", {12'h000, hit}, 16'h0000);
    check("clear_wins_stop", {15'h0, stop_req}, 16'h0000);

    // PASS write collides with a matching strobe: strobe ignored.
    step(1'b1, 1'b0, BASE + 2, 16'h0000, 1'b1, 16'h1111);
    check("pass_write_wins", {12'h000, hit}, 16'h0000);
    // VALUE write collides: strobe compares against old value.
    step(1'b1, 1'b0, BASE + 0, 16'h7777, 1'b1, 16'h1111);
    check("value_write_old_cmp", {12'h000, hit}, 16'h0001);

    // Reset mid-count.
    wr(BASE + 2, 16'h0005); wr(BASE + 3, 16'h0001); wr(BASE + 0, 16'h1111);
    stb(16'h1111); stb(16'h1111);
    #2 rst_n = 1'b0;
    #1 check("async_rst_hit", {12'h000, hit}, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4 * NCH + 4; i++) begin
      rd(BASE + 16'(i));
      check($sformatf("post_rst_reg_%0d", i), data_out, 16'h0000);
    end

    // Outside the window.
    wr(BASE + 0, 16'hBEEF);
    rd(BASE + 16'(4 * NCH + 5));
    check("oow_read", data_out, 16'h0000);
    wr(BASE + 16'(4 * NCH + 5), 16'hFFFF);
    check("oow_write_done", {15'h0, write_done}, 16'h0000);
    wr(BASE - 1, 16'h0007);
    check("below_write_done", {15'h0, write_done}, 16'h0000);
    wr(BASE + 16'(4 * NCH + 3), 16'h0007);
    check("reserved_ack", {15'h0, write_done}, 16'h0001);
    rd(BASE + 0);
    check("value_intact", data_out, 16'hBEEF);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      off = $urandom_range(0, 4 * NCH + 6) - 1;
      a = BASE + 16'(off);
      if (off == 4 * NCH + 1 && $urandom_range(0, 3) != 0) a = BASE + 16'(4 * NCH + 2);
      if (off < 0) d = 16'h0;
      else if (off % 4 == 0) d = pool[$urandom_range(0, 3)];
      else if (off % 4 == 1) d = igns[$urandom_range(0, 3)];
      else d = 16'($urandom_range(0, 7));
      v = pool[$urandom_range(0, 3)] ^ 16'($urandom_range(0, 1) * $urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: step(1'b1, 1'b0, a, d, 1'($urandom_range(0, 1)), v);
        1: step(1'b0, 1'b1, a, d, 1'($urandom_range(0, 1)), v);
        default: step(1'b0, 1'b0, a, d, 1'b1, v);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
